// File: rtl/jtframe_ddr_rdarb.sv
// Two-port DDRAM burst-read arbiter: round-robin grant, one burst per grant, data steered to owner.
// Latency: req -> ddram_rd next cycle; accept -> ack next cycle; dout_ready -> dv/dout next cycle.
// Backpressure: ddram_busy freezes the command phase; a burst with no data for 2^TOW cycles aborts with err.
module jtframe_ddr_rdarb #(
  parameter int TOW = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [28:0] i_addr0,
  input  logic [28:0] i_addr1,
  input  logic [7:0]  i_burst0,
  input  logic [7:0]  i_burst1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic        o_dv0,
  output logic        o_dv1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_err,
  output logic [63:0] o_dout,
  input  logic        i_ddram_busy,
  output logic        o_ddram_rd,
  output logic [28:0] o_ddram_addr,
  output logic [7:0]  o_ddram_burstcnt,
  output logic [7:0]  o_ddram_be,
  input  logic [63:0] i_ddram_dout,
  input  logic        i_ddram_dout_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // Abort fires on the idle cycle that takes the timer to all-ones, so the
  // timer saturates there and done lands 2^TOW-1 idle cycles after the last word.
  localparam logic [TOW-1:0] TMO_HIT = {{(TOW-1){1'b1}}, 1'b0};

  state_t          r_state, w_next;
  logic            r_sel, r_last, r_err;
  logic            r_ack0, r_ack1, r_dv0, r_dv1, r_done0, r_done1;
  logic [63:0]     r_dout;
  logic [28:0]     r_addr;
  logic [7:0]      r_cnt, r_rem;
  logic [TOW-1:0]  r_tmo;

  logic            w_grant, w_gsel, w_accept, w_word, w_last_word, w_abort;
  logic [7:0]      w_gburst;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_CMD;
      ST_CMD:  if (w_accept) w_next = ST_DATA;
      ST_DATA: if (w_last_word || w_abort) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output/control decode: grant choice, command accept, data word, burst end
  always_comb begin
    w_grant     = (r_state == ST_IDLE) && (i_req0 || i_req1);
    // On a tie the port not served last wins; otherwise whichever asks
    w_gsel      = (i_req0 && i_req1) ? ~r_last : i_req1;
    w_gburst    = w_gsel ? i_burst1 : i_burst0;
    w_accept    = (r_state == ST_CMD) && !i_ddram_busy;
    w_word      = (r_state == ST_DATA) && i_ddram_dout_ready;
    w_last_word = w_word && (r_rem == 8'd1);
    w_abort     = (r_state == ST_DATA) && !i_ddram_dout_ready && (r_tmo == TMO_HIT);
    o_ddram_rd  = (r_state == ST_CMD);
  end

  // Datapath: latched command, burst/timeout counters and registered per-port strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_dv0   <= 1'b0;
      r_dv1   <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_dout  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_tmo   <= '0;
    end else begin
      r_ack0  <= w_accept && !r_sel;
      r_ack1  <= w_accept &&  r_sel;
      r_dv0   <= w_word && !r_sel;
      r_dv1   <= w_word &&  r_sel;
      r_done0 <= (w_last_word || w_abort) && !r_sel;
      r_done1 <= (w_last_word || w_abort) &&  r_sel;
      if (w_grant) begin
        r_sel  <= w_gsel;
        r_addr <= w_gsel ? i_addr1 : i_addr0;
        r_cnt  <= (w_gburst == 8'd0) ? 8'd1 : w_gburst;
        r_err  <= 1'b0;
      end
      if (w_accept) begin
        r_rem <= r_cnt;
        r_tmo <= '0;
      end
      if (w_word) begin
        r_rem  <= r_rem - 8'd1;
        r_dout <= i_ddram_dout;
        r_tmo  <= '0;
      end else if (r_state == ST_DATA) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_last_word || w_abort) r_last <= r_sel;
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign o_ack0           = r_ack0;
  assign o_ack1           = r_ack1;
  assign o_dv0            = r_dv0;
  assign o_dv1            = r_dv1;
  assign o_done0          = r_done0;
  assign o_done1          = r_done1;
  assign o_err            = r_err;
  assign o_dout           = r_dout;
  assign o_ddram_addr     = r_addr;
  assign o_ddram_burstcnt = r_cnt;
  assign o_ddram_be       = 8'hFF;

endmodule

// File: tb/tb_jtframe_ddr_rdarb.sv
`timescale 1ns/1ps
module tb_jtframe_ddr_rdarb;
  localparam int TOW = 4;
  localparam int K_CMD = 0, K_ACK = 1, K_DV = 2, K_TMO = 3;

  logic        clk = 1'b0;
  logic        rst, req0, req1, busy, rdy;
  logic [28:0] addr0, addr1;
  logic [7:0]  burst0, burst1;
  logic [63:0] ddr_dout;
  logic        ack0, ack1, dv0, dv1, done0, done1, err, rd;
  logic [63:0] dout;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_cnt, ddr_be;

  always #5 clk = ~clk;

  jtframe_ddr_rdarb #(.TOW(TOW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1),
    .i_addr0(addr0), .i_addr1(addr1),
    .i_burst0(burst0), .i_burst1(burst1),
    .o_ack0(ack0), .o_ack1(ack1),
    .o_dv0(dv0), .o_dv1(dv1),
    .o_done0(done0), .o_done1(done1),
    .o_err(err), .o_dout(dout),
    .i_ddram_busy(busy), .o_ddram_rd(rd),
    .o_ddram_addr(ddr_addr), .o_ddram_burstcnt(ddr_cnt),
    .o_ddram_be(ddr_be), .i_ddram_dout(ddr_dout),
    .i_ddram_dout_ready(rdy)
  );

  typedef struct {
    int          kind;
    int          port;
    logic [28:0] addr;
    logic [7:0]  cnt;
    logic [63:0] dat;
    logic        done;
    logic        err;
  } ev_t;

  ev_t exq[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  function automatic logic [63:0] wdat(input int b, input int i);
    return {32'hDA7A_0000 + 32'(b), 32'(i)};
  endfunction

  function automatic ev_t mk(input int k, input int p, input logic [28:0] a, input logic [7:0] c,
                             input logic [63:0] d, input logic dn, input logic er);
    ev_t e;
    e.kind = k; e.port = p; e.addr = a; e.cnt = c; e.dat = d; e.done = dn; e.err = er;
    return e;
  endfunction

  task automatic push_cmd(input logic [28:0] a, input logic [7:0] c);
    exq.push_back(mk(K_CMD, 0, a, c, 64'd0, 1'b0, 1'b0));
  endtask
  task automatic push_ack(input int p);
    exq.push_back(mk(K_ACK, p, 29'd0, 8'd0, 64'd0, 1'b0, 1'b0));
  endtask
  task automatic push_dv(input int p, input logic [63:0] d, input logic dn, input logic er);
    exq.push_back(mk(K_DV, p, 29'd0, 8'd0, d, dn, er));
  endtask
  task automatic push_tmo(input int p);
    exq.push_back(mk(K_TMO, p, 29'd0, 8'd0, 64'd0, 1'b1, 1'b1));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard side: pop the oldest expected event and compare every field
  task automatic mon_cmp(input ev_t got, input string what);
    ev_t e;
    vectors++;
    if (exq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event port %0d addr %h cnt %0d dat %h done %0b err %0b",
               what, got.port, got.addr, got.cnt, got.dat, got.done, got.err);
    end else begin
      e = exq.pop_front();
      if (e.kind != got.kind || e.port != got.port || e.addr !== got.addr || e.cnt !== got.cnt ||
          e.dat !== got.dat || e.done !== got.done || e.err !== got.err) begin
        miscompares++;
        $display("FAIL %s: got kind %0d port %0d addr %h cnt %0d dat %h done %0b err %0b, want kind %0d port %0d addr %h cnt %0d dat %h done %0b err %0b",
                 what, got.kind, got.port, got.addr, got.cnt, got.dat, got.done, got.err,
                 e.kind, e.port, e.addr, e.cnt, e.dat, e.done, e.err);
      end
    end
  endtask

  // Monitor: every accepted command, ack, data word and timeout-done is checked in order
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack0 || ack1 || dv0 || dv1 || done0 || done1) begin
        vectors++;
        if ((ack0 && ack1) || (dv0 && dv1) || (done0 && done1)) begin
          miscompares++;
          $display("FAIL port_excl: ack %b%b dv %b%b done %b%b, want one port at most",
                   ack1, ack0, dv1, dv0, done1, done0);
        end
      end
      if (rd && !busy)
        mon_cmp(mk(K_CMD, 0, ddr_addr, ddr_cnt, 64'd0, 1'b0, 1'b0), "cmd");
      if (ack0 || ack1)
        mon_cmp(mk(K_ACK, ack1 ? 1 : 0, 29'd0, 8'd0, 64'd0, 1'b0, 1'b0), "ack");
      if (dv0 || dv1)
        mon_cmp(mk(K_DV, dv1 ? 1 : 0, 29'd0, 8'd0, dout, dv1 ? done1 : done0, err), "dv");
      else if (done0 || done1)
        mon_cmp(mk(K_TMO, done1 ? 1 : 0, 29'd0, 8'd0, 64'd0, 1'b1, err), "timeout_done");
    end
  end

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; busy = 1'b0; rdy = 1'b0; ddr_dout = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Bounded wait for a cycle with rd=1 and busy=0; returns just after the accepting edge
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (rd && !busy) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: no command accepted within 64 cycles, want one", name);
    end
    @(posedge clk); #1;
  endtask

  // Return n words at one per cycle, starting in the current cycle
  task automatic feed(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      ddr_dout = wdat(b, i); rdy = 1'b1;
      @(posedge clk); #1;
    end
    rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    addr0 = '0; addr1 = '0; burst0 = '0; burst1 = '0;
    do_reset();
    @(negedge clk);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_addr", 64'(ddr_addr), 64'd0);
    check("rst_cnt", 64'(ddr_cnt), 64'd0);
    check("rst_strobes", 64'({ack0, ack1, dv0, dv1, done0, done1}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dout", dout, 64'd0);
    check("be_const", 64'(ddr_be), 64'hFF);
    mon_en = 1'b1;

    // Single port 0 burst of 4
    @(posedge clk); #1;
    push_cmd(29'h3000000, 8'd4); push_ack(0);
    for (int i = 0; i < 4; i++) push_dv(0, wdat(1, i), i == 3, 1'b0);
    addr0 = 29'h3000000; burst0 = 8'd4; req0 = 1'b1;
    @(negedge clk); check("req_to_rd_n", 64'(rd), 64'd0);
    @(negedge clk); check("req_to_rd_n1", 64'(rd), 64'd1);
    @(posedge clk); #1;
    feed(1, 4);
    req0 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Tie: both held, grants alternate 0,1,0,1
    do_reset();
    addr0 = 29'h100; addr1 = 29'h200; burst0 = 8'd2; burst1 = 8'd2;
    for (int j = 0; j < 4; j++) begin
      push_cmd((j % 2) ? 29'h200 : 29'h100, 8'd2); push_ack(j % 2);
      push_dv(j % 2, wdat(10 + j, 0), 1'b0, 1'b0);
      push_dv(j % 2, wdat(10 + j, 1), 1'b1, 1'b0);
    end
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_accept("rr_accept");
      feed(10 + j, 2);
      if (j == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    repeat (3) @(posedge clk); #1;

    // Busy stall of 5 cycles in CMD
    do_reset();
    push_cmd(29'h40, 8'd1); push_ack(0); push_dv(0, wdat(20, 0), 1'b1, 1'b0);
    addr0 = 29'h40; burst0 = 8'd1; busy = 1'b1; req0 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_rd_held", 64'(rd), 64'd1);
      check("busy_addr_held", 64'(ddr_addr), 64'h40);
      check("busy_no_ack", 64'({ack0, dv0}), 64'd0);
      @(posedge clk);
    end
    #1 busy = 1'b0;
    wait_accept("busy_accept");
    feed(20, 1);
    req0 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset during DATA after 2 of 8 words, stray words afterwards
    do_reset();
    push_cmd(29'h55, 8'd8); push_ack(0);
    push_dv(0, wdat(30, 0), 1'b0, 1'b0); push_dv(0, wdat(30, 1), 1'b0, 1'b0);
    addr0 = 29'h55; burst0 = 8'd8; req0 = 1'b1;
    wait_accept("mid_rst_accept");
    feed(30, 2);
    rst = 1'b1; req0 = 1'b0; rdy = 1'b1; ddr_dout = wdat(31, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_rd", 64'(rd), 64'd0);
    check("midrst_strobes", 64'({ack0, ack1, dv0, dv1, done0, done1, err}), 64'd0);
    check("midrst_dout", dout, 64'd0);
    check("midrst_cmd", 64'({ddr_addr, ddr_cnt}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy = 1'b0;
    push_cmd(29'h77, 8'd2); push_ack(1);
    push_dv(1, wdat(32, 0), 1'b0, 1'b0); push_dv(1, wdat(32, 1), 1'b1, 1'b0);
    addr1 = 29'h77; burst1 = 8'd2; req1 = 1'b1;
    wait_accept("post_rst_accept");
    feed(32, 2);
    req1 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Timeout: burst 3, one word, then silence
    push_cmd(29'h99, 8'd3); push_ack(0); push_dv(0, wdat(40, 0), 1'b0, 1'b0); push_tmo(0);
    addr0 = 29'h99; burst0 = 8'd3; req0 = 1'b1;
    wait_accept("tmo_accept");
    ddr_dout = wdat(40, 0); rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); check("tmo_not_early", 64'(done0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("tmo_done", 64'(done0), 64'd1);
    check("tmo_err", 64'(err), 64'd1);
    req0 = 1'b0; rdy = 1'b1; ddr_dout = wdat(41, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    check("tmo_err_sticky", 64'(err), 64'd1);
    check("tmo_late_no_dv", 64'(dv0), 64'd0);

    // burst1 = 0 becomes a one-word burst; the grant clears err
    push_cmd(29'h1234, 8'd1); push_ack(1); push_dv(1, wdat(50, 0), 1'b1, 1'b0);
    addr1 = 29'h1234; burst1 = 8'd0; busy = 1'b1; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("grant_clears_err", 64'(err), 64'd0);
    check("b0_rd", 64'(rd), 64'd1);
    check("b0_cnt", 64'(ddr_cnt), 64'd1);
    @(posedge clk); #1 busy = 1'b0;
    wait_accept("b0_accept");
    feed(50, 1);
    req1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtframe_ddr_rdarb.md
# jtframe_ddr_rdarb

Two-port read arbiter and sequencer for the MiSTer DDR3 burst-read interface. It shares one DDRAM read channel between two requesters (port 0: ROM-dump/download engine, port 1: auxiliary reader such as NVRAM or sample streaming). It issues one burst per grant, steers returned 64-bit words to the granted port, and alternates ownership round-robin. It sits between the core-side download logic and the framework DDRAM pins.

## Interface
- TOW, 10, timeout counter width; a burst aborts after 2^TOW cycles without a data word
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  burst request, held high until doneN
- addr0 / addr1  in  29  64-bit-word burst start address, sampled at grant
- burst0 / burst1  in  8  words in burst; 0 treated as 1
- ack0 / ack1  out  1  one-cycle pulse when DDR accepts the command for that port
- dv0 / dv1  out  1  one-cycle strobe, dout holds a word for that port
- done0 / done1  out  1  one-cycle pulse with the last dv, or on timeout
- err  out  1  high with doneN when the burst ended by timeout; cleared at next grant
- dout  out  64  registered data word
- ddram_busy  in  1  controller stall
- ddram_rd  out  1  read command
- ddram_addr  out  29  burst address
- ddram_burstcnt  out  8  burst length
- ddram_be  out  8  constant 8'hFF
- ddram_dout  in  64  read data
- ddram_dout_ready  in  1  read data valid

## Operation
- States: IDLE, CMD, DATA.
- IDLE: if any reqN, grant. Both high: grant the port not served last; `last` resets to 1, so port 0 wins the first tie. Latch sel, addr, burst (0→1) into ddram_addr/ddram_burstcnt. Go to CMD.
- CMD: ddram_rd=1, addr/burstcnt stable. On a cycle with ddram_rd=1 and !ddram_busy, the command is accepted: ackSel pulses next cycle, ddram_rd drops, remaining=burst, timeout=0, go to DATA. While busy, hold everything.
- DATA: each ddram_dout_ready decrements remaining, registers dout, and pulses dvSel next cycle. When remaining reaches 1, the same word pulses doneSel, last<=sel, and the FSM goes to IDLE. Timeout increments on cycles without dout_ready. At all-ones: doneSel=1, err=1, go to IDLE, and ignore later words from that burst.
- dout_ready in IDLE/CMD is ignored; no dv is produced.
- reqN dropped mid-burst: the burst still completes and dv/done still pulse; the requester discards the data.
- Non-selected port outputs stay 0 throughout.
- Width rules: remaining is 8 bits and counts down; burst=128 gives 128 dv pulses. Timeout is TOW bits and saturates at abort.

## Timing
- Reset values: ddram_rd=0, ddram_addr=0, ddram_burstcnt=0, ack*/dv*/done*=0, err=0, dout=0, state=IDLE, last=1.
- Reset mid-burst: IDLE next cycle, ddram_rd=0; trailing DDR words are ignored.
- req sampled high in cycle n (IDLE) → ddram_rd=1 in cycle n+1.
- Command accepted in cycle m (rd=1, busy=0) → ack in m+1, ddram_rd=0 in m+1.
- dout_ready in cycle k → dv and dout valid in k+1; done is coincident with the last dv.
- Back-to-back: after done, FSM is in IDLE; a still-high req is regranted next cycle. Minimum gap between bursts on the DDR side is 2 cycles.
- Requests need no setup relative to done; a new reqN rise in the done cycle is seen in IDLE.

## Test plan
- Single port: req0, addr0=0x3000000, burst0=4, busy=0, 4 words at 1/cycle → rd for 1 cycle with addr 0x3000000, cnt 4; ack0 ×1; dv0 ×4 with matching data; done0 on the 4th dv; dv1/done1 never.
- Tie and round robin: req0 and req1 held high, burst=2 each, for 4 bursts → grant order 0,1,0,1; each ack precedes its dvs; no overlap.
- Busy stall: busy=1 for 5 cycles during CMD → rd and addr held 5 cycles; ack only after busy falls; no early dv.
- Timeout, TOW=4: burst=3, only 1 word returned → after 15 idle cycles done0=1 and err=1; a late word arriving in IDLE produces no dv; next grant clears err.
- Reset mid-DATA after 2 of 8 words → next cycle all outputs 0, state IDLE; stray words give no dv; new req1 is granted normally.
- burst1=0 → ddram_burstcnt=1, one dv1 with done1.
